modn_down_timer: RTL and testbench
==================================

MODN_DOWN_TIMER -- requirements
Module: modn_down_timer

Interface
REQ-001 Parameter N, default 10, modulus: count range 0..N-1.
REQ-002 Parameter WIDTH, default 4, count width; SHALL satisfy 2**WIDTH >= N, N >= 2.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin or restart a countdown from the sanitised load_val.
REQ-006 stop  input  1  abort the countdown and return to IDLE.
REQ-007 auto_reload  input  1  1 = wrap from 0 to N-1 and keep running; 0 = one-shot.
REQ-008 load_val  input  WIDTH  countdown start value, sampled only when a start is accepted.
REQ-009 count  output  WIDTH  current counter value, registered.
REQ-010 busy  output  1  high while the FSM is in RUN, registered.
REQ-011 tc  output  1  terminal-count flag, registered; high exactly in cycles where busy=1 and count=0.
REQ-012 done  output  1  high while the FSM is in DONE, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 Sanitised load value L SHALL be N-1 when load_val is 0 or load_val > N-1; otherwise L = load_val.
REQ-015 A start sampled at edge k in IDLE, DONE or RUN SHALL set count=L, state=RUN and busy=1 after edge k, and clear done.
REQ-016 In RUN with count > 0 and no start or stop, each edge SHALL decrement count by 1.
REQ-017 In RUN with count = 0 and auto_reload = 1, the next edge SHALL load N-1 and stay in RUN, giving the wrap 0 -> N-1.
REQ-018 In RUN with count = 0 and auto_reload = 0, the next edge SHALL enter DONE, hold count at 0 and set done=1 with busy=0.
REQ-019 tc SHALL be a single-cycle pulse per terminal count and SHALL never be high outside RUN.
REQ-020 A one-shot run from a start at edge k SHALL reach done=1 after edge k+L+1.
REQ-021 A stop sampled in RUN SHALL enter IDLE with count held at its current value, busy=0 and tc=0.
REQ-022 A stop sampled in IDLE or DONE SHALL enter IDLE with count held.
REQ-023 When start and stop are sampled in the same cycle, stop SHALL win.
REQ-024 A start in RUN SHALL restart from L regardless of the current count.
REQ-025 auto_reload SHALL be evaluated only at the count=0 edge; changes mid-run SHALL take effect at the next terminal count.
REQ-026 The decrement SHALL never underflow below 0, and count SHALL never exceed N-1.
REQ-027 With no start or stop, IDLE and DONE SHALL hold all outputs.

Reset
REQ-028 rst=1 at a clock edge SHALL force state=IDLE, count=0, busy=0, tc=0 and done=0, overriding start and stop.
REQ-029 Reset asserted mid-countdown SHALL abort the countdown with no further tc or done.
REQ-030 After rst deasserts, the block SHALL stay in IDLE until a start is sampled.

Structure
REQ-031 Package modn_timer_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the state-width constant.
REQ-032 The block SHALL be a single module with no sub-module; the FSM and down-counter share one always block set.
REQ-033 The block SHALL contain no latches, and no combinational path SHALL exist from inputs to outputs.

Verification (N=10, WIDTH=4)
REQ-034 rst for 2 cycles, then idle for 3 cycles -> count=0 and busy=tc=done=0 throughout.
REQ-035 start=1 for one cycle, load_val=3, auto_reload=0 -> count 3,2,1,0; tc high only at 0; then done=1 with count=0 held.
REQ-036 start with load_val=0 and then with load_val=12 -> both loads give count=9; auto_reload=1 gives the sequence 9..0,9..0 with a tc pulse at each 0.
REQ-037 start with load_val=7, then stop at count=4 -> IDLE with count=4 held and busy=0; a new start with load_val=2 -> count 2,1,0, then done.
REQ-038 start and stop asserted together in RUN -> IDLE; start in RUN at count=5 with load_val=8 -> count=8 next cycle.
REQ-039 rst asserted at count=2 in one-shot mode -> count=0 and IDLE next cycle, with no tc or done pulse afterwards.

Source files
------------

// File: rtl/modn_timer_pkg.sv
// Shared types for the mod-N down timer.
// State encoding and width live here so the bench and RTL agree.
package modn_timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/modn_down_timer.sv
// Mod-N down timer with one-shot / auto-reload modes.
// All outputs are registered from the next-state values.
module modn_down_timer
  import modn_timer_pkg::*;
#(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(N - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_s;
  logic             busy_d;
  logic             tc_d;
  logic             done_d;

  // Out-of-range or zero loads fall back to a full period.
  assign load_s = (load_val == '0 || load_val > TOP)
                ? TOP : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      busy    <= busy_d;
      tc      <= tc_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      count_d = load_s;
    end else begin
      unique case (state_q)
        RUN: begin
          if (count == '0) begin
            if (auto_reload) count_d = TOP;
            else             state_d = DONE;
          end else begin
            count_d = count - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    tc_d   = busy_d && (count_d == '0);
  end

endmodule

// File: tb/tb_modn_down_timer.sv
// Self-checking bench for modn_down_timer (N=10, WIDTH=4).
// Directed tables, hand sequences, then random against a model.
module tb_modn_down_timer;

  localparam int N = 10;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int compared = 0;
  int mismatched = 0;

  // Reference model: phase 0=idle 1=running 2=finished.
  int m_ph = 0;
  int m_cnt = 0;

  typedef struct {
    bit r, s, p, a;
    int lv;
    int c;
    bit b, t, d;
  } vec_t;

  vec_t tbl[$];

  modn_down_timer #(.N(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .auto_reload(auto_reload),
    .load_val(load_val),
    .count(count),
    .busy(busy),
    .tc(tc),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic model(input bit r, s, p, a, input int lv);
    if (r) begin
      m_ph = 0; m_cnt = 0;
    end else if (p) begin
      m_ph = 0;
    end else if (s) begin
      m_ph = 1;
      m_cnt = (lv == 0 || lv > N - 1) ? N - 1 : lv;
    end else if (m_ph == 1) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (a) m_cnt = N - 1;
      else m_ph = 2;
    end
  endtask

  task automatic step(input bit r, s, p, a, input int lv);
    rst = r; start = s; stop = p;
    auto_reload = a; load_val = W'(lv);
    @(posedge clk);
    model(r, s, p, a, lv);
    #1;
  endtask

  task automatic chk(input string nm, input int c,
                     input bit b, t, d);
    compared++;
    if (int'(count) != c || busy !== b || tc !== t || done !== d) begin
      mismatched++;
      $display("FAIL %s: got cnt=%0d b=%0b tc=%0b d=%0b exp cnt=%0d b=%0b tc=%0b d=%0b",
               nm, count, busy, tc, done, c, b, t, d);
    end
  endtask

  task automatic push(input bit r, s, p, a, input int lv,
                      input int c, input bit b, t, d);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.a = a; v.lv = lv;
    v.c = c; v.b = b; v.t = t; v.d = d;
    tbl.push_back(v);
  endtask

  task automatic seq(input bit r, s, p, a, input int lv,
                     input string nm, input int c,
                     input bit b, t, d);
    step(r, s, p, a, lv);
    chk(nm, c, b, t, d);
  endtask

  initial begin
    // reset then idle
    push(1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1, 1, 0, 0, 5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // one-shot from 3
    push(0, 1, 0, 0, 3, 3, 1, 0, 0);
    push(0, 0, 0, 0, 0, 2, 1, 0, 0);
    push(0, 0, 0, 0, 0, 1, 1, 0, 0);
    push(0, 0, 0, 0, 0, 0, 1, 1, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // sanitised loads and auto-reload wrap
    push(0, 1, 0, 1, 0, 9, 1, 0, 0);
    push(0, 1, 0, 1, 12, 9, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = (k == 0 ? 8 : 9); i >= 0; i--)
        push(0, 0, 0, 1, 0, i, 1, i == 0, 0);
    end
    push(0, 0, 0, 1, 0, 9, 1, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].lv);
      chk($sformatf("vec%0d", i), tbl[i].c,
          tbl[i].b, tbl[i].t, tbl[i].d);
    end

    // stop mid-run, hold, restart one-shot
    seq(0, 1, 0, 0, 7, "ld7", 7, 1, 0, 0);
    seq(0, 0, 0, 0, 0, "dec6", 6, 1, 0, 0);
    seq(0, 0, 0, 0, 0, "dec5", 5, 1, 0, 0);
    seq(0, 0, 0, 0, 0, "dec4", 4, 1, 0, 0);
    seq(0, 0, 1, 0, 0, "stop4", 4, 0, 0, 0);
    seq(0, 0, 0, 0, 0, "hold4", 4, 0, 0, 0);
    seq(0, 1, 0, 0, 2, "ld2", 2, 1, 0, 0);
    seq(0, 0, 0, 0, 0, "dec1", 1, 1, 0, 0);
    seq(0, 0, 0, 0, 0, "tc0", 0, 1, 1, 0);
    seq(0, 0, 0, 0, 0, "done", 0, 0, 0, 1);
    seq(0, 0, 1, 0, 0, "stopdone", 0, 0, 0, 0);

    // start+stop collision, restart in run
    seq(0, 1, 0, 0, 9, "ld9", 9, 1, 0, 0);
    seq(0, 0, 0, 0, 0, "dec8", 8, 1, 0, 0);
    seq(0, 1, 1, 0, 3, "stopwins", 8, 0, 0, 0);
    seq(0, 1, 0, 0, 9, "ld9b", 9, 1, 0, 0);
    for (int i = 8; i >= 5; i--)
      seq(0, 0, 0, 0, 0, "run", i, 1, 0, 0);
    seq(0, 1, 0, 0, 8, "restart8", 8, 1, 0, 0);

    // reset mid-countdown
    seq(0, 1, 0, 0, 5, "ld5", 5, 1, 0, 0);
    for (int i = 4; i >= 2; i--)
      seq(0, 0, 0, 0, 0, "dn", i, 1, 0, 0);
    seq(1, 0, 0, 0, 0, "rstmid", 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      seq(0, 0, 0, 0, 0, "postrst", 0, 0, 0, 0);

    // randomized against the model
    begin
      bit r, s, p, a;
      int lv;
      a = 0;
      for (int i = 0; i < 3000; i++) begin
        r = ($urandom_range(0, 99) < 2);
        s = ($urandom_range(0, 99) < 10);
        p = ($urandom_range(0, 99) < 5);
        if ($urandom_range(0, 99) < 4) a = ~a;
        lv = $urandom_range(0, 15);
        step(r, s, p, a, lv);
        chk($sformatf("rnd%0d", i), m_cnt, m_ph == 1,
            m_ph == 1 && m_cnt == 0, m_ph == 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
